// File: rtl/sound_i2s_pkg.sv
// Shared constants for the I2S transmitter: the dither LFSR and the frame-length helper.
// The LFSR items are only used when SOUND_I2S_TX_DITHER_EN is defined.
package sound_i2s_pkg;

    localparam int LFSR_W = 16;

    typedef logic [LFSR_W-1:0] lfsr_t;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form: feedback from bits 0,2,3,5
    localparam lfsr_t LFSR_TAPS = 16'h002D;
    localparam lfsr_t LFSR_SEED = 16'hACE1;

    function automatic lfsr_t lfsr_next(input lfsr_t state);
        return {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
    endfunction

    function automatic int frame_len(input int bclk_div, input int slot_width);
        return 4 * bclk_div * slot_width;
    endfunction

endpackage

// File: rtl/sound_i2s_quantizer.sv
// Reduces one signed mixer sample to the DAC width by arithmetic truncation.
// With SOUND_I2S_TX_DITHER_EN the low LFSR bits are added first and positive overflow saturates.
module sound_i2s_quantizer
    import sound_i2s_pkg::*;
#(
    parameter int IN_WIDTH     = 16,
    parameter int SAMPLE_WIDTH = 16
) (
`ifdef SOUND_I2S_TX_DITHER_EN
    input  lfsr_t                          lfsr,
`endif
    input  logic signed [IN_WIDTH-1:0]     sample_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out
);

    localparam int DROP = IN_WIDTH - SAMPLE_WIDTH;

`ifdef SOUND_I2S_TX_DITHER_EN
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr;
`endif

    generate
        if (DROP <= 0) begin : g_identity
            assign sample_out = sample_in;
        end else begin : g_reduce
`ifdef SOUND_I2S_TX_DITHER_EN
            logic [IN_WIDTH:0] dither;
            logic [IN_WIDTH:0] sum;
            logic              unused_sum_low;

            always_comb begin
                dither = '0;
                for (int i = 0; i < DROP && i < LFSR_W; i++) begin
                    dither[i] = lfsr[i];
                end
                sum = {sample_in[IN_WIDTH-1], sample_in} + dither;
                // the added value is never negative, so only the positive side can overflow
                if (!sum[IN_WIDTH] && sum[IN_WIDTH-1]) begin
                    sample_out = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
                end else begin
                    sample_out = sum[IN_WIDTH-1 -: SAMPLE_WIDTH];
                end
            end

            assign unused_sum_low = ^sum[DROP-1:0];
`else
            logic unused_low;
            assign unused_low = ^sample_in[DROP-1:0];
            assign sample_out = sample_in[IN_WIDTH-1 -: SAMPLE_WIDTH];
`endif
        end
    endgenerate

endmodule

// File: rtl/sound_i2s_tx.sv
// Philips I2S transmitter: captures both mixer channels once per frame and shifts them out MSB first.
// Optional dither before truncation is enabled by defining SOUND_I2S_TX_DITHER_EN.
module sound_i2s_tx
    import sound_i2s_pkg::*;
#(
    parameter int IN_WIDTH     = 16,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic signed [IN_WIDTH-1:0] SOUND_L,
    input  logic signed [IN_WIDTH-1:0] SOUND_R,
    input  logic                       MUTE,
    output logic                       I2S_BCLK,
    output logic                       I2S_LRCK,
    output logic                       I2S_DATA,
    output logic                       FRAME_START
);

    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int IDX_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    generate
        if (SAMPLE_WIDTH > IN_WIDTH) begin : g_err_sample_width
            $error("sound_i2s_tx: SAMPLE_WIDTH must not exceed IN_WIDTH");
        end
        if (SLOT_WIDTH <= SAMPLE_WIDTH) begin : g_err_slot_width
            $error("sound_i2s_tx: SLOT_WIDTH must be greater than SAMPLE_WIDTH");
        end
        if (BCLK_DIV < 1) begin : g_err_bclk_div
            $error("sound_i2s_tx: BCLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0]               div_cnt;
    logic [BIT_W-1:0]               bit_cnt;
    logic [BIT_W-1:0]               bit_nxt;
    logic                           bclk_q;
    logic                           lrck_q;
    logic                           data_q;
    logic                           fs_q;
    logic signed [SAMPLE_WIDTH-1:0] hold_l;
    logic signed [SAMPLE_WIDTH-1:0] hold_r;
    logic signed [SAMPLE_WIDTH-1:0] q_l;
    logic signed [SAMPLE_WIDTH-1:0] q_r;
    logic                           fall_evt;
    logic                           lrck_nxt;
    logic                           data_nxt;
    logic [IDX_W-1:0]               idx_l;
    logic [IDX_W-1:0]               idx_r;
    int                             bit_idx;

`ifdef SOUND_I2S_TX_DITHER_EN
    lfsr_t lfsr_q;

    sound_i2s_quantizer #(
        .IN_WIDTH     (IN_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_quant_l (
        .lfsr       (lfsr_q),
        .sample_in  (SOUND_L),
        .sample_out (q_l)
    );

    sound_i2s_quantizer #(
        .IN_WIDTH     (IN_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_quant_r (
        .lfsr       (lfsr_q),
        .sample_in  (SOUND_R),
        .sample_out (q_r)
    );
`else
    sound_i2s_quantizer #(
        .IN_WIDTH     (IN_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_quant_l (
        .sample_in  (SOUND_L),
        .sample_out (q_l)
    );

    sound_i2s_quantizer #(
        .IN_WIDTH     (IN_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_quant_r (
        .sample_in  (SOUND_R),
        .sample_out (q_r)
    );
`endif

    assign fall_evt = (div_cnt == DIV_LAST) && bclk_q;
    assign bit_nxt  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    assign lrck_nxt = (bit_nxt >= SLOT_B);

    // Data for the slot position being entered; the one-bit I2S delay puts the MSB at position 1.
    always_comb begin
        bit_idx  = int'(bit_nxt);
        idx_l    = IDX_W'(SAMPLE_WIDTH - bit_idx);
        idx_r    = IDX_W'(SLOT_WIDTH + SAMPLE_WIDTH - bit_idx);
        data_nxt = 1'b0;
        if (bit_idx >= 1 && bit_idx <= SAMPLE_WIDTH) begin
            data_nxt = hold_l[idx_l];
        end else if (bit_idx >= SLOT_WIDTH + 1 && bit_idx <= SLOT_WIDTH + SAMPLE_WIDTH) begin
            data_nxt = hold_r[idx_r];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt <= '0;
            bclk_q  <= 1'b0;
            bit_cnt <= BIT_LAST;
            lrck_q  <= 1'b1;
            data_q  <= 1'b0;
            fs_q    <= 1'b0;
            hold_l  <= '0;
            hold_r  <= '0;
`ifdef SOUND_I2S_TX_DITHER_EN
            lfsr_q  <= LFSR_SEED;
`endif
        end else begin
            fs_q <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk_q  <= ~bclk_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (fall_evt) begin
                bit_cnt <= bit_nxt;
                lrck_q  <= lrck_nxt;
                data_q  <= data_nxt;
                // frame boundary: latch both channels so the mixer levels can move freely
                if (bit_nxt == '0) begin
                    hold_l <= MUTE ? '0 : q_l;
                    hold_r <= MUTE ? '0 : q_r;
                    fs_q   <= 1'b1;
`ifdef SOUND_I2S_TX_DITHER_EN
                    lfsr_q <= lfsr_next(lfsr_q);
`endif
                end
            end
        end
    end

    assign I2S_BCLK    = bclk_q;
    assign I2S_LRCK    = lrck_q;
    assign I2S_DATA    = data_q;
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_sound_i2s_tx.sv
// Directed bench for sound_i2s_tx: default 16-bit instance plus an 18-to-16-bit instance.
// Expectations for the 18-bit instance follow SOUND_I2S_TX_DITHER_EN when it is defined.
module tb_sound_i2s_tx;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] sound_l;
    logic [15:0] sound_r;
    logic        mute;
    logic        bclk16, lrck16, data16, fs16;
    logic [17:0] sound_l18;
    logic [17:0] sound_r18;
    logic        mute18;
    logic        bclk18, lrck18, data18, fs18;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] LRCK_EXP = 64'hFFFF_FFFF_0000_0000;

    always #5 CLK = ~CLK;

    sound_i2s_tx u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SOUND_L     (sound_l),
        .SOUND_R     (sound_r),
        .MUTE        (mute),
        .I2S_BCLK    (bclk16),
        .I2S_LRCK    (lrck16),
        .I2S_DATA    (data16),
        .FRAME_START (fs16)
    );

    sound_i2s_tx #(
        .IN_WIDTH     (18),
        .SAMPLE_WIDTH (16)
    ) u_dut18 (
        .CLK         (CLK),
        .RESET       (RESET),
        .SOUND_L     (sound_l18),
        .SOUND_R     (sound_r18),
        .MUTE        (mute18),
        .I2S_BCLK    (bclk18),
        .I2S_LRCK    (lrck18),
        .I2S_DATA    (data18),
        .FRAME_START (fs18)
    );

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        mute;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // Expected DATA seen on BCLK rises 1..64 of a frame (index = slot position b).
    function automatic logic [63:0] exp_bits(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] v;
        v = '0;
        for (int k = 1; k <= 16; k++) begin
            v[k]      = l[16-k];
            v[32 + k] = r[16-k];
        end
        return v;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] q18(input logic [17:0] x, input logic [15:0] st);
`ifdef SOUND_I2S_TX_DITHER_EN
        int v;
        v = int'($signed(x)) + int'(st[1:0]);
        if (v > 131071) return 16'h7FFF;
        return v[17:2];
`else
        logic [1:0] ignored;
        ignored = st[1:0];
        return x[17:2] | {14'd0, ignored & 2'b00};
`endif
    endfunction

    task automatic wait_fs(input bit sel, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 2000 && !ok) begin
            @(negedge CLK);
            cycles++;
            if ((sel ? fs18 : fs16) === 1'b1) ok = 1'b1;
        end
    endtask

    // Called right after FRAME_START is seen; collects DATA/LRCK on the next 64 BCLK rises.
    task automatic grab(input bit sel, output logic [63:0] dbits, output logic [63:0] lbits,
                        output int cycles);
        logic prev, cur;
        int   rises;
        prev   = sel ? bclk18 : bclk16;
        rises  = 0;
        cycles = 0;
        dbits  = '0;
        lbits  = '0;
        while (rises < 64 && cycles < 1000) begin
            @(negedge CLK);
            cycles++;
            cur = sel ? bclk18 : bclk16;
            if (cur === 1'b1 && prev === 1'b0) begin
                dbits[rises] = sel ? data18 : data16;
                lbits[rises] = sel ? lrck18 : lrck16;
                rises++;
            end
            prev = cur;
        end
    endtask

    int          cyc;
    int          gcyc;
    bit          ok;
    logic [63:0] db;
    logic [63:0] lb;
    logic [15:0] st;

    initial begin
        vecs[0] = '{16'h8001, 16'h1234, 1'b0, 16'h8001, 16'h1234};
        vecs[1] = '{16'h7FFF, 16'h8000, 1'b0, 16'h7FFF, 16'h8000};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0001};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 16'h0000};
        vecs[4] = '{16'h0000, 16'hC3A9, 1'b0, 16'h0000, 16'hC3A9};

        RESET     = 1'b1;
        sound_l   = 16'h8001;
        sound_r   = 16'h1234;
        mute      = 1'b0;
        sound_l18 = 18'h1FFFF;
        sound_r18 = 18'h00002;
        mute18    = 1'b0;
        repeat (4) @(negedge CLK);
        check("reset_outs", {60'd0, bclk16, lrck16, data16, fs16}, 64'b0100);
        check("reset_outs18", {60'd0, bclk18, lrck18, data18, fs18}, 64'b0100);

        // first frame after reset release
        RESET = 1'b0;
        wait_fs(0, cyc, ok);
        check("first_fs_latency", cyc, 8);
        check("first_fs_lrck", {63'd0, lrck16}, 64'd0);
        grab(0, db, lb, gcyc);
        check("frame1_data", db, exp_bits(16'h8001, 16'h1234));
        check("frame1_lrck", lb, LRCK_EXP);
        wait_fs(0, cyc, ok);
        check("frame_period", gcyc + cyc, 512);

        // input change at cycle 100 of a frame only reaches the next frame
        fork
            grab(0, db, lb, gcyc);
            begin
                repeat (100) @(negedge CLK);
                sound_l = 16'h7FFF;
            end
        join
        check("midchange_cur", db, exp_bits(16'h8001, 16'h1234));
        wait_fs(0, cyc, ok);
        check("midchange_fs", {63'd0, ok}, 64'd1);
        grab(0, db, lb, gcyc);
        check("midchange_next", db, exp_bits(16'h7FFF, 16'h1234));

        // mute asserted mid-frame
        wait_fs(0, cyc, ok);
        fork
            grab(0, db, lb, gcyc);
            begin
                repeat (100) @(negedge CLK);
                mute = 1'b1;
            end
        join
        check("mute_cur", db, exp_bits(16'h7FFF, 16'h1234));
        wait_fs(0, cyc, ok);
        check("mute_period", gcyc + cyc, 512);
        grab(0, db, lb, gcyc);
        check("mute_next", db, 64'd0);
        check("mute_lrck", lb, LRCK_EXP);
        wait_fs(0, cyc, ok);
        check("mute_period2", gcyc + cyc, 512);
        grab(0, db, lb, gcyc);
        check("mute_still", db, 64'd0);

        for (int i = 0; i < 5; i++) begin
            sound_l = vecs[i].l;
            sound_r = vecs[i].r;
            mute    = vecs[i].mute;
            wait_fs(0, cyc, ok);
            check($sformatf("vec%0d_period", i), gcyc + cyc, 512);
            grab(0, db, lb, gcyc);
            check($sformatf("vec%0d_data", i), db, exp_bits(vecs[i].exp_l, vecs[i].exp_r));
        end

        // reset 300 cycles into a frame (BCLK is high there)
        sound_l = 16'h8001;
        sound_r = 16'h1234;
        mute    = 1'b0;
        wait_fs(0, cyc, ok);
        repeat (300) @(negedge CLK);
        check("pre_reset_bclk", {63'd0, bclk16}, 64'd1);
        RESET = 1'b1;
        @(negedge CLK);
        check("midreset_outs", {60'd0, bclk16, lrck16, data16, fs16}, 64'b0100);
        @(negedge CLK);
        RESET = 1'b0;
        wait_fs(0, cyc, ok);
        check("restart_fs_latency", cyc, 8);
        grab(0, db, lb, gcyc);
        check("restart_data", db, exp_bits(16'h8001, 16'h1234));
        check("restart_lrck", lb, LRCK_EXP);

        // 18-bit instance, fresh reset so the dither sequence starts at the seed
        RESET     = 1'b1;
        sound_l18 = 18'h1FFFF;
        sound_r18 = 18'h00002;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        st = 16'hACE1;
        for (int f = 0; f < 64; f++) begin
            wait_fs(1, cyc, ok);
            check($sformatf("w18_fs%0d", f), {63'd0, ok}, 64'd1);
            grab(1, db, lb, gcyc);
            check($sformatf("w18_a%0d", f), db,
                  exp_bits(q18(18'h1FFFF, st), q18(18'h00002, st)));
            st = lfsr_step(st);
        end
        sound_l18 = 18'h3FFFF;
        sound_r18 = 18'h00007;
        for (int f = 0; f < 8; f++) begin
            wait_fs(1, cyc, ok);
            grab(1, db, lb, gcyc);
            check($sformatf("w18_b%0d", f), db,
                  exp_bits(q18(18'h3FFFF, st), q18(18'h00007, st)));
            check($sformatf("w18_b%0d_lrck", f), lb, LRCK_EXP);
            st = lfsr_step(st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d of %0d comparisons bad", n_bad, n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
